// File: rtl/dtc_seq_engine.sv
// Sequential decision-tree classifier: walks one node of a loadable table per clock.
// Optional macro DTC_PERF_CNT_EN builds the completed-classification counter on perf_cnt.
module dtc_seq_engine #(
    parameter int N_FEAT        = 12,
    parameter int CLS_W         = 3,
    parameter int NODE_AW       = 7,
    parameter int MAX_DEPTH     = 12,
    parameter int DEFAULT_CLASS = 0,
    parameter int FW            = $clog2(N_FEAT),
    parameter int ENT_W         = 1 + FW + 2*NODE_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [NODE_AW-1:0] cfg_addr,
    input  logic [ENT_W-1:0]   cfg_wdata,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_FEAT-1:0]  in_feat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLS_W-1:0]   out_class,
    output logic               out_err,
    output logic [31:0]        perf_cnt
);

    localparam int N_ENT   = 1 << NODE_AW;
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam logic [ENT_W-1:0] DEF_ENT =
        {1'b1, {(ENT_W-1-CLS_W){1'b0}}, CLS_W'(DEFAULT_CLASS)};

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   table_q [N_ENT];
    logic [NODE_AW-1:0] addr_q, addr_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [N_FEAT-1:0]  feat_q, feat_d;
    logic [CLS_W-1:0]   cls_q, cls_d;
    logic               err_q, err_d;
    logic               cfg_err_q;

    logic [ENT_W-1:0]   ent;
    logic [FW-1:0]      feat_idx;
    logic               feat_bit;
    logic [NODE_AW-1:0] next_addr;
    logic               cfg_wr;

    assign cfg_wr    = cfg_we && (state_q == S_IDLE);
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_class = cls_q;
    assign out_err   = err_q;
    assign cfg_err   = cfg_err_q;

    always_comb begin
        ent       = table_q[addr_q];
        feat_idx  = ent[2*NODE_AW +: FW];
        feat_bit  = 1'b0;
        // Indices past the last feature fall through and read as 0.
        for (int i = 0; i < N_FEAT; i++) begin
            if (feat_idx == FW'(i)) feat_bit = feat_q[i];
        end
        next_addr = feat_bit ? ent[0 +: NODE_AW] : ent[NODE_AW +: NODE_AW];
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        depth_d = depth_q;
        feat_d  = feat_q;
        cls_d   = cls_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    feat_d  = in_feat;
                    addr_d  = '0;
                    depth_d = '0;
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (ent[ENT_W-1]) begin
                    cls_d   = ent[CLS_W-1:0];
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                    cls_d   = CLS_W'(DEFAULT_CLASS);
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = next_addr;
                    depth_d = depth_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cls_q     <= '0;
            err_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            err_q     <= err_d;
            cfg_err_q <= cfg_we && (state_q != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        depth_q <= depth_d;
        feat_q  <= feat_d;
    end

    // Reset wipes the whole table back to default leaves; software reloads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENT; i++) table_q[i] <= DEF_ENT;
        end else if (cfg_wr) begin
            table_q[cfg_addr] <= cfg_wdata;
        end
    end

`ifdef DTC_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state_q == S_DONE) && out_ready) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cnt = perf_q;
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: doc/dtc_seq_engine.md
Name: dtc_seq_engine

Overview:
- Programmable, sequential decision-tree classifier; successor to the fixed combinational split trees.
- Tree topology lives in a loadable node table, so one netlist serves any trained tree of up to 2**NODE_AW nodes.
- Walks one node per clock over a captured binary feature vector; returns a class code through valid/ready handshakes.
- Sits between the feature extractor and the class consumer.

Parameters:
- N_FEAT, 12: number of binary input features.
- CLS_W, 3: class code width.
- NODE_AW, 7: node-table address width (128 entries).
- MAX_DEPTH, 12: maximum internal nodes visited per classification.
- DEFAULT_CLASS, 0: class returned on depth abort and held by empty entries.
- Derived: FW = clog2(N_FEAT); ENT_W = 1 + FW + 2*NODE_AW. Requires CLS_W <= 2*NODE_AW.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  NODE_AW  entry address.
- cfg_wdata  in  ENT_W  entry data.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  engine idle, can accept.
- in_feat  in  N_FEAT  feature vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_class  out  CLS_W  class code.
- out_err  out  1  result came from a depth abort.
- perf_cnt  out  32  completed-classification count (see Optional Feature).

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Entry format, MSB first: leaf(1), feat(FW), child0(NODE_AW), child1(NODE_AW).
  - Leaf entries: class is in the low CLS_W bits; the other fields are ignored.
  - Root is address 0.
  - Internal node: next = in_feat_q[feat] ? child1 : child0.
  - A feature index >= N_FEAT reads as 0.
- Reset values:
  - Every table entry = leaf with DEFAULT_CLASS.
  - FSM = IDLE.
  - in_ready = 1.
  - out_valid = 0, out_class = 0, out_err = 0, cfg_err = 0, perf_cnt = 0.
- FSM IDLE -> WALK -> DONE -> IDLE.
  - IDLE: in_ready = 1. On in_valid && in_ready, capture in_feat into in_feat_q, set addr = 0, depth = 0, go to WALK.
  - WALK: in_ready = 0. Evaluate entry[addr] combinationally.
    - Leaf: register out_class = class, out_err = 0, go to DONE.
    - Internal with depth == MAX_DEPTH: register out_class = DEFAULT_CLASS, out_err = 1, go to DONE.
    - Otherwise: addr <= next, depth <= depth + 1, stay in WALK.
  - DONE: out_valid = 1. out_class and out_err are held stable until out_ready. On out_ready, go to IDLE.
- Latency:
  - out_valid rises k+1 clocks after the accepting edge, where k is the number of internal nodes on the path.
  - Throughput: one result per k+3 clocks when out_ready is held high.
  - No back-to-back accept in the DONE cycle.
- Config writes:
  - Accepted only in IDLE, where they take effect on the next edge.
  - cfg_we outside IDLE: write dropped, cfg_err pulses for one cycle.
  - cfg_we and in_valid in the same IDLE cycle: both are honoured; the walk sees the new entry.
- Cycles (child pointing at an ancestor) are bounded by MAX_DEPTH and end in an abort. They never hang.
- rst mid-walk or in DONE:
  - FSM returns to IDLE and out_valid drops on the next edge.
  - The table is reinitialised to defaults; software must reload it.
- out_ready asserted outside DONE has no effect.

Optional Feature:
- Macro: DTC_PERF_CNT_EN.
- Defined:
  - perf_cnt increments by 1 on each DONE handshake (out_valid && out_ready).
  - Wraps at 2**32. Cleared by rst.
- Undefined: perf_cnt is tied to 0 and no counter logic is built.

Test Plan:
1. Reset with an empty table: accept in_feat = 12'hFFF -> out_valid 1 clock after accept, out_class = 0, out_err = 0.
2. Load a 3-node tree and classify two vectors:
   - Tree: node0 = internal feat 9, child0 = 1, child1 = 2; node1 = leaf 3'b000; node2 = leaf 3'b101.
   - in_feat bit9 = 1 -> out_class = 5 after 2 clocks.
   - in_feat bit9 = 0 -> out_class = 0.
3. Depth abort: node0 = internal, child0 = child1 = 0, MAX_DEPTH = 12 -> out_valid after 13 clocks, out_class = DEFAULT_CLASS, out_err = 1.
4. Backpressure: hold out_ready = 0 for 5 clocks in DONE -> out_class and out_valid stable, in_ready = 0, a second in_valid is not accepted. Release -> in_ready = 1 the next clock.
5. cfg_we during WALK -> cfg_err pulses for 1 cycle and the entry is unchanged (verified by re-classification). Assert rst mid-walk -> out_valid = 0, table back to defaults.
6. With DTC_PERF_CNT_EN: 7 completed handshakes -> perf_cnt = 7. Without the macro, perf_cnt = 0 throughout.
